// File: rtl/decode_issue_stage.sv
// +--------------------------------------------------------------------------+
// | decode_issue_stage: RV32I decode/issue with a busy-bit RAW scoreboard.   |
// | Optional: DECODE_ILLEGAL_TRAP_EN flags unknown opcodes as illegal.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module decode_issue_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            in_ready,
  output logic            rf_read_en,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  input  logic [XLEN-1:0] rf_data_1,
  input  logic [XLEN-1:0] rf_data_2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_op_a,
  output logic [XLEN-1:0] ex_op_b,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic [4:0]      ex_rd,
  output logic            ex_illegal
);

  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_REG    = 7'b0110011;

  localparam logic [2:0] c_FMT_R = 3'd0;
  localparam logic [2:0] c_FMT_I = 3'd1;
  localparam logic [2:0] c_FMT_S = 3'd2;
  localparam logic [2:0] c_FMT_B = 3'd3;
  localparam logic [2:0] c_FMT_U = 3'd4;
  localparam logic [2:0] c_FMT_J = 3'd5;

  // Decode slot
  logic            r_run;
  logic            r_d_valid;
  logic [XLEN-1:0] r_d_instr;
  logic [XLEN-1:0] r_d_pc;

  // Issue slot
  logic            r_ex_valid;
  logic [XLEN-1:0] r_ex_pc;
  logic [XLEN-1:0] r_ex_imm;
  logic [XLEN-1:0] r_ex_op_a;
  logic [XLEN-1:0] r_ex_op_b;
  logic [6:0]      r_ex_opcode;
  logic [2:0]      r_ex_funct3;
  logic [6:0]      r_ex_funct7;
  logic [4:0]      r_ex_rd;
  logic            r_ex_illegal;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [2:0]      w_fmt;
  logic            w_illegal;
  logic            w_uses_rs1;
  logic            w_uses_rs2;
  logic            w_writes_rd;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_hazard;
  logic            w_issue;
  logic            w_load;

  assign w_opcode = r_d_instr[6:0];
  assign w_rd     = r_d_instr[11:7];
  assign w_rs1    = r_d_instr[19:15];
  assign w_rs2    = r_d_instr[24:20];

  always_comb begin
    w_fmt     = c_FMT_R;
    w_illegal = 1'b0;
    case (w_opcode)
      c_OP_IMM, c_OP_LOAD, c_OP_JALR: w_fmt = c_FMT_I;
      c_OP_STORE:                     w_fmt = c_FMT_S;
      c_OP_BRANCH:                    w_fmt = c_FMT_B;
      c_OP_LUI, c_OP_AUIPC:           w_fmt = c_FMT_U;
      c_OP_JAL:                       w_fmt = c_FMT_J;
      c_OP_REG:                       w_fmt = c_FMT_R;
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        w_illegal = 1'b1;
`else
        w_fmt = c_FMT_R;
`endif
      end
    endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
    if (r_d_instr[1:0] != 2'b11) begin
      w_illegal = 1'b1;
    end
`endif
  end

  always_comb begin
    w_uses_rs1  = !w_illegal && (w_fmt == c_FMT_I || w_fmt == c_FMT_S ||
                                 w_fmt == c_FMT_B || w_fmt == c_FMT_R);
    w_uses_rs2  = !w_illegal && (w_fmt == c_FMT_S || w_fmt == c_FMT_B ||
                                 w_fmt == c_FMT_R);
    w_writes_rd = !w_illegal && !(w_fmt == c_FMT_S || w_fmt == c_FMT_B);

    w_imm32 = 32'd0;
    case (w_fmt)
      c_FMT_I: w_imm32 = {{20{r_d_instr[31]}}, r_d_instr[31:20]};
      c_FMT_S: w_imm32 = {{20{r_d_instr[31]}}, r_d_instr[31:25], r_d_instr[11:7]};
      c_FMT_B: w_imm32 = {{19{r_d_instr[31]}}, r_d_instr[31], r_d_instr[7],
                          r_d_instr[30:25], r_d_instr[11:8], 1'b0};
      c_FMT_U: w_imm32 = {r_d_instr[31:12], 12'd0};
      c_FMT_J: w_imm32 = {{11{r_d_instr[31]}}, r_d_instr[31], r_d_instr[19:12],
                          r_d_instr[20], r_d_instr[30:21], 1'b0};
      default: w_imm32 = 32'd0;
    endcase
    if (w_illegal) begin
      w_imm32 = 32'd0;
    end
  end

  assign w_imm = XLEN'($signed(w_imm32));

  // Hazards look only at the registered scoreboard; a retire is seen one cycle later.
  assign w_hazard = r_d_valid && ((w_uses_rs1 && r_busy[w_rs1]) ||
                                  (w_uses_rs2 && r_busy[w_rs2]));
  assign w_issue  = r_d_valid && !w_hazard && (!r_ex_valid || ex_ready);
  assign in_ready = r_run && (!r_d_valid || w_issue);
  assign w_load   = in_valid && in_ready;

  assign rf_read_en = w_issue;
  assign rf_rs1     = r_d_valid ? w_rs1 : 5'd0;
  assign rf_rs2     = r_d_valid ? w_rs2 : 5'd0;

  // Set is applied after clear so an issue and a retire to one register leave it busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid && wb_rd != 5'd0) begin
      w_busy_nxt[wb_rd] = 1'b0;
    end
    if (w_issue && w_writes_rd && w_rd != 5'd0) begin
      w_busy_nxt[w_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run     <= 1'b0;
      r_d_valid <= 1'b0;
      r_d_instr <= '0;
      r_d_pc    <= '0;
      r_busy    <= '0;
    end else begin
      r_run  <= 1'b1;
      r_busy <= w_busy_nxt;
      if (w_load) begin
        r_d_valid <= 1'b1;
        r_d_instr <= in_instr;
        r_d_pc    <= in_pc;
      end else if (w_issue) begin
        r_d_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ex_valid   <= 1'b0;
      r_ex_pc      <= '0;
      r_ex_imm     <= '0;
      r_ex_op_a    <= '0;
      r_ex_op_b    <= '0;
      r_ex_opcode  <= '0;
      r_ex_funct3  <= '0;
      r_ex_funct7  <= '0;
      r_ex_rd      <= '0;
      r_ex_illegal <= 1'b0;
    end else begin
      r_ex_valid <= w_issue || (r_ex_valid && !ex_ready);
      if (w_issue) begin
        r_ex_pc      <= r_d_pc;
        r_ex_imm     <= w_imm;
        r_ex_op_a    <= w_uses_rs1 ? rf_data_1 : '0;
        r_ex_op_b    <= w_uses_rs2 ? rf_data_2 : '0;
        r_ex_opcode  <= w_opcode;
        r_ex_funct3  <= r_d_instr[14:12];
        r_ex_funct7  <= r_d_instr[31:25];
        r_ex_rd      <= w_writes_rd ? w_rd : 5'd0;
        r_ex_illegal <= w_illegal;
      end
    end
  end

  assign ex_valid   = r_ex_valid;
  assign ex_pc      = r_ex_pc;
  assign ex_imm     = r_ex_imm;
  assign ex_op_a    = r_ex_op_a;
  assign ex_op_b    = r_ex_op_b;
  assign ex_opcode  = r_ex_opcode;
  assign ex_funct3  = r_ex_funct3;
  assign ex_funct7  = r_ex_funct7;
  assign ex_rd      = r_ex_rd;
  assign ex_illegal = r_ex_illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_issue_stage.sv
// +--------------------------------------------------------------------------+
// | tb_decode_issue_stage: directed and randomized bench for decode/issue.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_decode_issue_stage;

  localparam int c_NRAND = 300;
  localparam int c_MAXCYC = 20000;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        rf_read_en;
  logic [4:0]  rf_rs1;
  logic [4:0]  rf_rs2;
  logic [31:0] rf_data_1;
  logic [31:0] rf_data_2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_op_a;
  logic [31:0] ex_op_b;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic [4:0]  ex_rd;
  logic        ex_illegal;

  logic [31:0] regs [32];
  int n_run;
  int n_fail;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  decode_issue_stage #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
    .rf_read_en(rf_read_en), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_rd(ex_rd), .ex_illegal(ex_illegal)
  );

  // The bench plays the register file with fixed contents.
  assign rf_data_1 = regs[rf_rs1];
  assign rf_data_2 = regs[rf_rs2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference decode written straight from the RV32I field rules.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    bit r1, r2, wr, ill;
    e.pc  = pc;
    e.opc = ins[6:0];
    e.f3  = ins[14:12];
    e.f7  = ins[31:25];
    e.imm = 32'd0;
    r1 = 1; r2 = 1; wr = 1; ill = 0;
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        r2 = 0; e.imm = 32'($signed(ins[31:20]));
      end
      7'b0100011: begin
        wr = 0; e.imm = 32'($signed({ins[31:25], ins[11:7]}));
      end
      7'b1100011: begin
        wr = 0; e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        r1 = 0; r2 = 0; e.imm = ins & 32'hFFFFF000;
      end
      7'b1101111: begin
        r1 = 0; r2 = 0;
        e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      7'b0110011: ;
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        ill = 1;
`endif
      end
    endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
    if (ins[1:0] != 2'b11) ill = 1;
`endif
    if (ill) begin
      r1 = 0; r2 = 0; wr = 0; e.imm = 32'd0;
    end
    e.a   = r1 ? regs[ins[19:15]] : 32'd0;
    e.b   = r2 ? regs[ins[24:20]] : 32'd0;
    e.rd  = wr ? ins[11:7] : 5'd0;
    e.ill = ill;
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] ins;
    logic [6:0] opc;
    int k;
    k = $urandom_range(0, 11);
    case (k)
      0: opc = 7'b0010011;
      1: opc = 7'b0000011;
      2: opc = 7'b1100111;
      3: opc = 7'b0100011;
      4: opc = 7'b1100011;
      5: opc = 7'b0110111;
      6: opc = 7'b0010111;
      7: opc = 7'b1101111;
      8, 9: opc = 7'b0110011;
      10: opc = 7'b1111111;
      default: opc = 7'($urandom);
    endcase
    ins = $urandom;
    ins[6:0] = opc;
    return ins;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, sent, got;
    bit acc_in, acc_ex;
    exp_t q[$];
    exp_t e;
    logic [4:0] wbq[$];

    n_run = 0;
    n_fail = 0;
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : (32'hA5000000 + i * 32'h01010101);

    // Reset with a pending request
    reset_n = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h0;
    ex_ready = 1'b1; wb_valid = 1'b0; wb_rd = 5'd0;
    repeat (2) tick;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_pc", ex_pc, 0);
    chk("rst_ex_imm", ex_imm, 0);
    chk("rst_ex_ops", ex_op_a | ex_op_b, 0);
    chk("rst_ex_fields", {ex_opcode, ex_funct3, ex_funct7, ex_rd, ex_illegal}, 0);
    reset_n = 1'b1; in_valid = 1'b0;
    #1 chk("rel_in_ready_same", in_ready, 0);
    tick;
    chk("rel_in_ready_next", in_ready, 1);

    // addi x1,x0,5 then dependent add x2,x1,x1
    in_valid = 1; in_instr = 32'h00500093; in_pc = 32'h100;
    tick;
    in_instr = 32'h00108133; in_pc = 32'h104;
    #1 chk("addi_in_ready", in_ready, 1);
    tick;
    in_valid = 0;
    #1;
    chk("addi_valid", ex_valid, 1);
    chk("addi_imm", ex_imm, 5);
    chk("addi_rd", ex_rd, 1);
    chk("addi_pc", ex_pc, 32'h100);
    chk("addi_opcode", ex_opcode, 7'h13);
    chk("add_rf_rs1", rf_rs1, 1);
    chk("add_rf_rs2", rf_rs2, 1);
    tick;
    chk("add_stall1", ex_valid, 0);
    chk("add_stall_in_ready", in_ready, 0);
    chk("add_stall_rd_en", rf_read_en, 0);
    tick;
    chk("add_stall2", ex_valid, 0);
    wb_valid = 1; wb_rd = 5'd1;
    tick;
    wb_valid = 0;
    #1 chk("add_stall_after_wb", ex_valid, 0);
    tick;
    chk("add_valid", ex_valid, 1);
    chk("add_op_a", ex_op_a, regs[1]);
    chk("add_op_b", ex_op_b, regs[1]);
    chk("add_rd", ex_rd, 2);
    chk("add_pc", ex_pc, 32'h104);
    wb_valid = 1; wb_rd = 5'd2;
    tick;
    wb_valid = 0;

    // beq x0,x0,-4
    in_valid = 1; in_instr = 32'hFE000EE3; in_pc = 32'h200;
    tick;
    in_valid = 0;
    tick;
    chk("beq_valid", ex_valid, 1);
    chk("beq_imm", ex_imm, 32'hFFFFFFFC);
    chk("beq_rd", ex_rd, 0);
    chk("beq_opcode", ex_opcode, 7'h63);

    // lui x5 issues in the same cycle as a retire of x5; busy[5] must survive
    in_valid = 1; in_instr = 32'h123452B7; in_pc = 32'h300;
    tick;
    in_instr = 32'h00028333; in_pc = 32'h304;
    wb_valid = 1; wb_rd = 5'd5;
    tick;
    wb_valid = 0; in_valid = 0;
    #1;
    chk("lui_valid", ex_valid, 1);
    chk("lui_imm", ex_imm, 32'h12345000);
    chk("lui_rd", ex_rd, 5);
    tick;
    chk("lui_dep_stall1", ex_valid, 0);
    tick;
    chk("lui_dep_stall2", ex_valid, 0);
    wb_valid = 1; wb_rd = 5'd5;
    tick;
    wb_valid = 0;
    tick;
    chk("lui_dep_valid", ex_valid, 1);
    chk("lui_dep_op_a", ex_op_a, regs[5]);
    chk("lui_dep_op_b", ex_op_b, 0);
    chk("lui_dep_rd", ex_rd, 6);
    wb_valid = 1; wb_rd = 5'd6;
    tick;
    wb_valid = 0;

    // Backpressure after sw x2,0(x0)
    in_valid = 1; in_instr = 32'h00202023; in_pc = 32'h400;
    tick;
    in_instr = 32'h00700193; in_pc = 32'h404;
    tick;
    in_instr = 32'h00900213; in_pc = 32'h408;
    ex_ready = 0;
    #1;
    chk("sw_valid", ex_valid, 1);
    chk("sw_opcode", ex_opcode, 7'h23);
    chk("sw_op_b", ex_op_b, regs[2]);
    chk("sw_rd", ex_rd, 0);
    chk("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bp_hold_valid", ex_valid, 1);
      chk("bp_hold_pc", ex_pc, 32'h400);
      chk("bp_hold_op_b", ex_op_b, regs[2]);
      chk("bp_hold_funct3", ex_funct3, 2);
      chk("bp_hold_in_ready", in_ready, 0);
      chk("bp_hold_rd_en", rf_read_en, 0);
    end
    ex_ready = 1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_rd_en", rf_read_en, 1);
    tick;
    in_valid = 0;
    #1;
    chk("bp_next_pc", ex_pc, 32'h404);
    chk("bp_next_rd", ex_rd, 3);
    chk("bp_next_imm", ex_imm, 7);
    tick;
    chk("bp_last_pc", ex_pc, 32'h408);
    chk("bp_last_rd", ex_rd, 4);
    chk("bp_last_imm", ex_imm, 9);
    tick;
    chk("bp_no_dup", ex_valid, 0);
    wb_valid = 1; wb_rd = 5'd3;
    tick;
    wb_rd = 5'd4;
    tick;
    wb_valid = 0; wb_rd = 5'd0;

    // Unknown opcode 0x7F
    in_valid = 1; in_instr = 32'h0000007F; in_pc = 32'h500;
    tick;
    in_valid = 0;
    tick;
    chk("unk_valid", ex_valid, 1);
    chk("unk_pc", ex_pc, 32'h500);
    chk("unk_rd", ex_rd, 0);
    chk("unk_imm", ex_imm, 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("unk_illegal", ex_illegal, 1);
`else
    chk("unk_illegal", ex_illegal, 0);
`endif
    tick;

    // Randomized stream with random backpressure and out-of-band retires
    cyc = 0; sent = 0; got = 0;
    while (got < c_NRAND && cyc < c_MAXCYC) begin
      if (!in_valid && sent < c_NRAND && $urandom_range(0, 3) != 0) begin
        in_instr = gen_instr();
        in_pc = 32'h1000 + sent * 4;
        in_valid = 1;
      end
      ex_ready = ($urandom_range(0, 3) != 0);
      if (wbq.size() > 0 && $urandom_range(0, 1) == 1) begin
        wb_valid = 1; wb_rd = wbq.pop_front();
      end else begin
        wb_valid = 0; wb_rd = 5'd0;
      end
      #3;
      acc_in = in_valid && in_ready;
      acc_ex = ex_valid && ex_ready;
      if (acc_ex) begin
        if (q.size() == 0) begin
          chk("rand_spurious_issue", q.size(), 1);
        end else begin
          e = q.pop_front();
          got++;
          chk("rand_pc", ex_pc, e.pc);
          chk("rand_imm", ex_imm, e.imm);
          chk("rand_op_a", ex_op_a, e.a);
          chk("rand_op_b", ex_op_b, e.b);
          chk("rand_decode", {ex_opcode, ex_funct3, ex_funct7}, {e.opc, e.f3, e.f7});
          chk("rand_rd", ex_rd, e.rd);
          chk("rand_illegal", ex_illegal, e.ill);
          if (e.rd != 5'd0) wbq.push_back(e.rd);
        end
      end
      if (acc_in) begin
        q.push_back(model(in_instr, in_pc));
        sent++;
      end
      tick;
      cyc++;
      if (acc_in) in_valid = 0;
    end
    wb_valid = 0;
    chk("rand_all_issued", got, c_NRAND);
    chk("rand_queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
